tl_arb2: RTL and testbench



---
 rtl/tl_arb2.sv | 193 +++++++++++++++++++
 tb/tb_tl_arb2.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_arb2.sv
`timescale 1ns/1ps
// tl_arb2: round-robin arbiter that shares one TileLink-UL slave between the il1 (m0)
// and dl1 (m1) masters. A grant covers a whole transaction: all A beats, then all D beats.
module tl_arb2 #(
  parameter int AW    = 32,
  parameter int DW    = 128,
  parameter int SW    = 3,
  parameter int MAXSZ = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  // il1 master
  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [7:0]        m0_a_size,
  input  logic [SW-1:0]     m0_a_source,
  input  logic [AW-1:0]     m0_a_address,
  input  logic [DW/8-1:0]   m0_a_mask,
  input  logic [DW-1:0]     m0_a_data,
  input  logic              m0_a_corrupt,
  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_param,
  output logic [7:0]        m0_d_size,
  output logic [SW-1:0]     m0_d_source,
  output logic [SW-1:0]     m0_d_sink,
  output logic              m0_d_denied,
  output logic [DW-1:0]     m0_d_data,
  output logic              m0_d_corrupt,
  // dl1 master
  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [7:0]        m1_a_size,
  input  logic [SW-1:0]     m1_a_source,
  input  logic [AW-1:0]     m1_a_address,
  input  logic [DW/8-1:0]   m1_a_mask,
  input  logic [DW-1:0]     m1_a_data,
  input  logic              m1_a_corrupt,
  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_param,
  output logic [7:0]        m1_d_size,
  output logic [SW-1:0]     m1_d_source,
  output logic [SW-1:0]     m1_d_sink,
  output logic              m1_d_denied,
  output logic [DW-1:0]     m1_d_data,
  output logic              m1_d_corrupt,
  // shared slave
  output logic              s_a_valid,
  input  logic              s_a_ready,
  output logic [2:0]        s_a_opcode,
  output logic [2:0]        s_a_param,
  output logic [7:0]        s_a_size,
  output logic [SW-1:0]     s_a_source,
  output logic [AW-1:0]     s_a_address,
  output logic [DW/8-1:0]   s_a_mask,
  output logic [DW-1:0]     s_a_data,
  output logic              s_a_corrupt,
  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [2:0]        s_d_opcode,
  input  logic [1:0]        s_d_param,
  input  logic [7:0]        s_d_size,
  input  logic [SW-1:0]     s_d_source,
  input  logic [SW-1:0]     s_d_sink,
  input  logic              s_d_denied,
  input  logic [DW-1:0]     s_d_data,
  input  logic              s_d_corrupt
);

  typedef enum logic [1:0] {IDLE, ABEAT, DBEAT} state_e;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  state_e     r_state;
  logic       r_gnt;
  logic       r_last;
  logic       r_is_get;
  logic [4:0] r_cnt;

  logic       w_in_a;
  logic       w_in_d;
  logic       w_pick;
  logic       w_a_fire;
  logic       w_d_fire;
  logic       w_req_put;
  logic [2:0] w_req_op;
  logic [7:0] w_req_size;

  // Beats needed to move 2^size bytes over a 16-byte bus; oversized requests are clamped.
  function automatic logic [4:0] f_beats(input logic [7:0] size);
    logic [7:0] v_sz;
    v_sz = (size > 8'(MAXSZ)) ? 8'(MAXSZ) : size;
    if (v_sz <= 8'd4) return 5'd1;
    return 5'd1 << (v_sz - 8'd4);
  endfunction

  assign w_in_a = (r_state == ABEAT);
  assign w_in_d = (r_state == DBEAT);

  // On a tie the master not served last wins; r_last resets to 1 so m0 wins the first tie.
  assign w_pick     = (m0_a_valid && m1_a_valid) ? ~r_last : m1_a_valid;
  assign w_req_op   = w_pick ? m1_a_opcode : m0_a_opcode;
  assign w_req_size = w_pick ? m1_a_size   : m0_a_size;
  assign w_req_put  = (w_req_op == OP_PUT_FULL) || (w_req_op == OP_PUT_PART);

  assign s_a_valid   = w_in_a && (r_gnt ? m1_a_valid : m0_a_valid);
  assign m0_a_ready  = w_in_a && !r_gnt && s_a_ready;
  assign m1_a_ready  = w_in_a &&  r_gnt && s_a_ready;
  assign s_a_opcode  = r_gnt ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = r_gnt ? m1_a_param   : m0_a_param;
  assign s_a_size    = r_gnt ? m1_a_size    : m0_a_size;
  assign s_a_source  = r_gnt ? m1_a_source  : m0_a_source;
  assign s_a_address = r_gnt ? m1_a_address : m0_a_address;
  assign s_a_mask    = r_gnt ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = r_gnt ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = r_gnt ? m1_a_corrupt : m0_a_corrupt;

  // D payload is broadcast; only the valid is steered, so a stalled beat simply waits.
  assign m0_d_valid  = w_in_d && !r_gnt && s_d_valid;
  assign m1_d_valid  = w_in_d &&  r_gnt && s_d_valid;
  assign s_d_ready   = w_in_d && (r_gnt ? m1_d_ready : m0_d_ready);

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source;
  assign m0_d_sink    = s_d_sink;
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;
  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source;
  assign m1_d_sink    = s_d_sink;
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

  assign w_a_fire = s_a_valid && s_a_ready;
  assign w_d_fire = s_d_valid && s_d_ready;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_is_get <= 1'b0;
      r_cnt    <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_a_valid || m1_a_valid) begin
            r_gnt    <= w_pick;
            r_last   <= w_pick;
            r_is_get <= (w_req_op == OP_GET);
            r_cnt    <= w_req_put ? f_beats(w_req_size) : 5'd1;
            r_state  <= ABEAT;
          end
        end
        ABEAT: begin
          if (w_a_fire) begin
            if (r_cnt == 5'd1) begin
              // The final A beat still carries the request size, so the Get burst length comes from it.
              r_cnt   <= r_is_get ? f_beats(s_a_size) : 5'd1;
              r_state <= DBEAT;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        DBEAT: begin
          if (w_d_fire) begin
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_arb2.sv
`timescale 1ns/1ps
// tb_tl_arb2: directed stimulus for tl_arb2 with a behavioural slave; expected D beats are
// queued at issue time and a monitor pops and compares them as the masters accept beats.
module tb_tl_arb2;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 3;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;

  logic            m0_a_valid, m0_a_ready, m0_a_corrupt;
  logic [2:0]      m0_a_opcode, m0_a_param;
  logic [7:0]      m0_a_size;
  logic [SW-1:0]   m0_a_source;
  logic [AW-1:0]   m0_a_address;
  logic [DW/8-1:0] m0_a_mask;
  logic [DW-1:0]   m0_a_data;
  logic            m0_d_valid, m0_d_ready, m0_d_denied, m0_d_corrupt;
  logic [2:0]      m0_d_opcode;
  logic [1:0]      m0_d_param;
  logic [7:0]      m0_d_size;
  logic [SW-1:0]   m0_d_source, m0_d_sink;
  logic [DW-1:0]   m0_d_data;

  logic            m1_a_valid, m1_a_ready, m1_a_corrupt;
  logic [2:0]      m1_a_opcode, m1_a_param;
  logic [7:0]      m1_a_size;
  logic [SW-1:0]   m1_a_source;
  logic [AW-1:0]   m1_a_address;
  logic [DW/8-1:0] m1_a_mask;
  logic [DW-1:0]   m1_a_data;
  logic            m1_d_valid, m1_d_ready, m1_d_denied, m1_d_corrupt;
  logic [2:0]      m1_d_opcode;
  logic [1:0]      m1_d_param;
  logic [7:0]      m1_d_size;
  logic [SW-1:0]   m1_d_source, m1_d_sink;
  logic [DW-1:0]   m1_d_data;

  logic            s_a_valid, s_a_ready, s_a_corrupt;
  logic [2:0]      s_a_opcode, s_a_param;
  logic [7:0]      s_a_size;
  logic [SW-1:0]   s_a_source;
  logic [AW-1:0]   s_a_address;
  logic [DW/8-1:0] s_a_mask;
  logic [DW-1:0]   s_a_data;
  logic            s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
  logic [2:0]      s_d_opcode;
  logic [1:0]      s_d_param;
  logic [7:0]      s_d_size;
  logic [SW-1:0]   s_d_source, s_d_sink;
  logic [DW-1:0]   s_d_data;

  tl_arb2 #(.AW(AW), .DW(DW), .SW(SW), .MAXSZ(8)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_a_corrupt(m0_a_corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m0_d_corrupt(m0_d_corrupt),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_a_corrupt(m1_a_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .m1_d_corrupt(m1_d_corrupt),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .s_d_corrupt(s_d_corrupt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            master;
    logic [2:0]    opcode;
    logic [SW-1:0] source;
    logic [7:0]    size;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]    opcode;
    logic [SW-1:0] source;
    logic [7:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } abeat_t;

  exp_t   exp_q[$];
  exp_t   rq[$];
  abeat_t a_log[$];
  bit     rdy_pat[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     d_hs[2] = '{0, 0};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a, input int b);
    return {32'(b), 32'hCAFE_F00D, ~a, a};
  endfunction

  function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a, input int b);
    return {a, 32'(b), 32'h5A5A_0000, ~a};
  endfunction

  function automatic int nbeats(input logic [7:0] sz);
    int s;
    s = (sz > 8'd8) ? 8 : int'(sz);
    return (s <= 4) ? 1 : (1 << (s - 4));
  endfunction

  task automatic expect_get(input int m, input logic [SW-1:0] src, input logic [7:0] sz,
                            input logic [AW-1:0] addr, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back('{m, 3'd1, src, sz, rdata(addr, b)});
  endtask

  task automatic expect_ack(input int m, input logic [SW-1:0] src, input logic [7:0] sz);
    exp_q.push_back('{m, 3'd0, src, sz, '0});
  endtask

  task automatic drive(input int m, input logic v, input logic [2:0] op, input logic [7:0] sz,
                       input logic [SW-1:0] src, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_source = src;
      m0_a_address = addr; m0_a_data = d;
    end else begin
      m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_source = src;
      m1_a_address = addr; m1_a_data = d;
    end
  endtask

  // Drives n A beats on master m; called and returns 1 ns after a rising edge.
  task automatic issue(input int m, input logic [2:0] op, input logic [7:0] sz,
                       input logic [SW-1:0] src, input logic [AW-1:0] addr, input int n);
    bit hs;
    int cyc;
    for (int b = 0; b < n; b++) begin
      drive(m, 1'b1, op, sz, src, addr, wdata(addr, b));
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 200) begin
        @(negedge CLK);
        hs = (m == 0) ? (m0_a_valid && m0_a_ready) : (m1_a_valid && m1_a_ready);
        @(posedge CLK);
        #1;
        cyc++;
      end
      if (!hs) check("a_handshake_timeout", DW'(0), DW'(1));
    end
    drive(m, 1'b0, op, sz, src, addr, '0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(posedge CLK);
      c++;
    end
    check(name, DW'(exp_q.size()), DW'(0));
    exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    drive(0, 1'b0, 3'd0, 8'd0, '0, '0, '0);
    drive(1, 1'b0, 3'd0, 8'd0, '0, '0, '0);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    a_log.delete();
  endtask

  // Behavioural slave: zero-wait D responses, s_a_ready taken from rdy_pat (default 1).
  initial begin
    bit     hs_a, hs_d;
    abeat_t ab;
    int     put_cnt;
    put_cnt = 0;
    s_a_ready = 1'b1; s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
    s_d_source = '0; s_d_sink = 3'd5; s_d_denied = 1'b0; s_d_data = '0; s_d_corrupt = 1'b0;
    forever begin
      @(negedge CLK);
      hs_a = s_a_valid && s_a_ready;
      hs_d = s_d_valid && s_d_ready;
      ab   = '{s_a_opcode, s_a_source, s_a_size, s_a_address, s_a_data};
      @(posedge CLK);
      #2;
      if (!RSTn) begin
        rq.delete();
        rdy_pat.delete();
        put_cnt   = 0;
        s_a_ready = 1'b1;
      end else begin
        if (hs_d && rq.size() > 0) rq.delete(0);
        if (hs_a) begin
          a_log.push_back(ab);
          if (ab.opcode == 3'd4) begin
            for (int b = 0; b < nbeats(ab.size); b++)
              rq.push_back('{0, 3'd1, ab.source, ab.size, rdata(ab.addr, b)});
          end else if (ab.opcode == 3'd0 || ab.opcode == 3'd1) begin
            put_cnt++;
            if (put_cnt == nbeats(ab.size)) begin
              rq.push_back('{0, 3'd0, ab.source, ab.size, '0});
              put_cnt = 0;
            end
          end else begin
            rq.push_back('{0, 3'd0, ab.source, ab.size, '0});
          end
        end
        s_a_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      end
      s_d_valid = (rq.size() > 0);
      if (rq.size() > 0) begin
        s_d_opcode = rq[0].opcode; s_d_source = rq[0].source;
        s_d_size   = rq[0].size;   s_d_data   = rq[0].data;
      end
    end
  end

  task automatic mon_port(input int m);
    logic          v, r;
    logic [2:0]    op;
    logic [SW-1:0] src, snk;
    logic [7:0]    sz;
    logic [DW-1:0] d;
    logic          den;
    exp_t          e;
    v   = (m == 0) ? m0_d_valid  : m1_d_valid;
    r   = (m == 0) ? m0_d_ready  : m1_d_ready;
    op  = (m == 0) ? m0_d_opcode : m1_d_opcode;
    src = (m == 0) ? m0_d_source : m1_d_source;
    snk = (m == 0) ? m0_d_sink   : m1_d_sink;
    sz  = (m == 0) ? m0_d_size   : m1_d_size;
    d   = (m == 0) ? m0_d_data   : m1_d_data;
    den = (m == 0) ? m0_d_denied : m1_d_denied;
    if (v && (exp_q.size() == 0 || exp_q[0].master != m))
      check($sformatf("m%0d_d_valid_unexpected", m), DW'(v), DW'(0));
    else if (v && r) begin
      e = exp_q.pop_front();
      d_hs[m]++;
      check($sformatf("m%0d_d_opcode", m), DW'(op), DW'(e.opcode));
      check($sformatf("m%0d_d_source", m), DW'(src), DW'(e.source));
      check($sformatf("m%0d_d_size", m), DW'(sz), DW'(e.size));
      check($sformatf("m%0d_d_data", m), d, e.data);
      check($sformatf("m%0d_d_sink_denied", m), DW'({snk, den}), DW'({3'd5, 1'b0}));
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RSTn) begin
        mon_port(0);
        mon_port(1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    int            c;
    int            base1;
    m0_a_param = '0; m0_a_mask = '1; m0_a_corrupt = 1'b0; m0_d_ready = 1'b1;
    m1_a_param = '0; m1_a_mask = '1; m1_a_corrupt = 1'b0; m1_d_ready = 1'b1;
    drive(0, 1'b0, 3'd0, 8'd0, '0, '0, '0);
    drive(1, 1'b0, 3'd0, 8'd0, '0, '0, '0);
    #3;
    check("reset_outputs_zero",
          DW'({s_a_valid, m0_a_ready, m1_a_ready, s_d_ready, m0_d_valid, m1_d_valid}), DW'(0));
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // 1: single m0 Get, one-cycle arbitration latency.
    expect_get(0, 3'd2, 8'd4, 32'h8000_0000, 1);
    fork
      issue(0, 3'd4, 8'd4, 3'd2, 32'h8000_0000, 1);
      begin
        @(negedge CLK);
        check("t1_idle_cycle_s_a_valid", DW'(s_a_valid), DW'(0));
        @(negedge CLK);
        check("t1_s_a_valid_latency", DW'(s_a_valid), DW'(1));
        check("t1_s_a_address", DW'(s_a_address), DW'(32'h8000_0000));
      end
    join
    wait_drain("t1_drain", 50);
    check("t1_a_beats", DW'(a_log.size()), DW'(1));

    // 2: tie after reset goes to m0; m0 re-requesting in the bubble loses to waiting m1.
    do_reset();
    expect_get(0, 3'd0, 8'd4, 32'h8000_0100, 1);
    expect_get(1, 3'd1, 8'd4, 32'h8000_0200, 1);
    expect_get(0, 3'd2, 8'd4, 32'h8000_0300, 1);
    fork
      begin
        issue(0, 3'd4, 8'd4, 3'd0, 32'h8000_0100, 1);
        issue(0, 3'd4, 8'd4, 3'd2, 32'h8000_0300, 1);
      end
      issue(1, 3'd4, 8'd4, 3'd1, 32'h8000_0200, 1);
    join
    wait_drain("t2_drain", 100);
    check("t2_a_order", DW'({a_log[0].source, a_log[1].source, a_log[2].source}),
          DW'({3'd0, 3'd1, 3'd2}));

    // 3: m1 Get size 6 gives 4 D beats; a later m0 request waits for all of them.
    expect_get(1, 3'd1, 8'd6, 32'h8000_1000, 4);
    expect_get(0, 3'd4, 8'd4, 32'h8000_2000, 1);
    base1 = d_hs[1];
    fork
      issue(1, 3'd4, 8'd6, 3'd1, 32'h8000_1000, 1);
      begin
        repeat (2) @(posedge CLK);
        #1;
        issue(0, 3'd4, 8'd4, 3'd4, 32'h8000_2000, 1);
        check("t3_m0_granted_after_4_beats", DW'(d_hs[1] - base1), DW'(4));
      end
    join
    wait_drain("t3_drain", 100);

    // 4: m0 PutFullData size 5 with s_a_ready stalling between the two beats.
    a_log.delete();
    expect_ack(0, 3'd3, 8'd5);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    issue(0, 3'd0, 8'd5, 3'd3, 32'h8000_3000, 2);
    wait_drain("t4_drain", 50);
    check("t4_a_beats", DW'(a_log.size()), DW'(2));
    check("t4_a_beat0_data", a_log[0].data, wdata(32'h8000_3000, 0));
    check("t4_a_beat1_data", a_log[1].data, wdata(32'h8000_3000, 1));

    // 5: m0 holds d_ready low for 3 cycles; slave sees no ready, payload holds, no beat lost.
    m0_d_ready = 1'b0;
    expect_get(0, 3'd5, 8'd5, 32'h8000_4000, 2);
    issue(0, 3'd4, 8'd5, 3'd5, 32'h8000_4000, 1);
    c = 0;
    @(negedge CLK);
    while (!m0_d_valid && c < 50) begin
      @(negedge CLK);
      c++;
    end
    check("t5_d_arrives", DW'(m0_d_valid), DW'(1));
    d0 = m0_d_data;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      check("t5_s_d_ready_low", DW'(s_d_ready), DW'(0));
      check("t5_d_valid_held", DW'(m0_d_valid), DW'(1));
      check("t5_d_data_stable", m0_d_data, d0);
    end
    @(posedge CLK);
    #1;
    m0_d_ready = 1'b1;
    wait_drain("t5_drain", 50);

    // 6: asynchronous reset mid-ABEAT, then a tie goes to m0 again.
    for (int i = 0; i < 8; i++) rdy_pat.push_back(1'b0);
    drive(0, 1'b1, 3'd0, 8'd5, 3'd6, 32'h8000_5000, wdata(32'h8000_5000, 0));
    @(negedge CLK);
    @(negedge CLK);
    check("t6_in_abeat", DW'(s_a_valid), DW'(1));
    #1;
    RSTn = 1'b0;
    #1;
    check("t6_async_reset_outputs",
          DW'({s_a_valid, m0_a_ready, m1_a_ready, s_d_ready, m0_d_valid, m1_d_valid}), DW'(0));
    do_reset();
    expect_get(0, 3'd0, 8'd4, 32'h8000_6000, 1);
    expect_get(1, 3'd7, 8'd4, 32'h8000_7000, 1);
    fork
      issue(0, 3'd4, 8'd4, 3'd0, 32'h8000_6000, 1);
      issue(1, 3'd4, 8'd4, 3'd7, 32'h8000_7000, 1);
    join
    wait_drain("t6_drain", 100);

    repeat (3) @(posedge CLK);
    check("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
